ps2_kbd_rx: RTL and testbench

PS/2 keyboard receiver with an output FIFO. It samples the raw `ps2_clk`/`ps2_data` lines and deserialises 11-bit frames. It validates each frame and buffers the received scan-code bytes. A valid/ready port presents the bytes to the downstream scan-code-to-ASCII and seven-segment lookup stage, which is built from the key-match mux templates.

---
 rtl/ps2_kbd_rx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: 3-flop line synchronisers, 11-bit frame deserialiser and scan-code FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity; otherwise only the stop bit is checked.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a start bit (data low on a ps2_clk fall)
// ST_SHIFT | capturing data, parity and stop bits; watchdog running
// ST_CHECK | one cycle: validate frame, push / drop / flag error
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } state_e;

  // Synchronisers: bit 0 = s0, bit 1 = s1, bit 2 = s2
  logic [2:0]  clk_sync_q, clk_sync_d;
  logic [2:0]  data_sync_q, data_sync_d;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:1] frame_q, frame_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic        overflow_q, overflow_d;

  logic fe;
  logic data_bit;
  logic frame_good;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic set_ovf;
  logic unused_ok;

  assign clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
  assign data_sync_d = {data_sync_q[1:0], ps2_data};

  assign fe       = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_bit = data_sync_q[1];

  // frame_q[8:1] data LSB first, [9] parity, [10] stop
`ifdef PS2_PARITY_CHECK_EN
  assign frame_good = frame_q[10] & (^frame_q[9:1]);
`else
  assign frame_good = frame_q[10];
`endif

  assign unused_ok = ^{data_sync_q[2], frame_q[9]};

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & out_ready;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    wdog_d    = wdog_q;
    push      = 1'b0;
    set_ovf   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (fe && !data_bit) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 4'd1;
        end
      end

      ST_SHIFT: begin
        if (fe) begin
          frame_d = {data_bit, frame_q[10:2]};
          wdog_d  = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d   = ST_CHECK;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          // Keyboard went quiet mid-frame: abandon silently
          state_d   = ST_IDLE;
          bit_cnt_d = 4'd0;
          wdog_d    = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      ST_CHECK: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 4'd0;
        wdog_d    = '0;
        if (frame_good) begin
          if (!fifo_full || pop) begin
            push = 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 4'd0;
        wdog_d    = '0;
      end
    endcase
  end

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q | set_ovf;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = frame_q[8:1];
      wptr_d                = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      frame_q     <= '0;
      wdog_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      wdog_q      <= wdog_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
    end
  end

  assign out_valid  = ~fifo_empty;
  assign out_data   = mem_q[rptr_q[AW-1:0]];
  assign fifo_count = wptr_q - rptr_q;
  assign overflow   = overflow_q;
  assign frame_err  = (state_q == ST_CHECK) & ~frame_good;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: bit-banged PS/2 frames in, expected bytes queued and
// compared as the consumer pops them.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_cycles = 0;
  int exp_err_cycles = 0;
  logic [7:0] exp_q[$];

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer side of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cycles++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", exp_q.size(), 1);
        else chk("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input logic par_flip, input logic stop);
    return {stop, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  // mode 0: plain; 1: out_ready high in the CHECK cycle; 2: latency checks around CHECK
  task automatic send(input logic [10:0] bits, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (10) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (i == 10 && mode != 0) begin
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        if (mode == 1) out_ready = 1'b1;
        if (mode == 2) begin
          chk("lat_valid_n1", out_valid, 0);
          chk("lat_count_n1", fifo_count, 0);
          chk("lat_err_n1", frame_err, 0);
        end
        @(posedge clk);
        #1;
        if (mode == 1) out_ready = 1'b0;
        if (mode == 2) begin
          chk("lat_valid_n2", out_valid, 1);
          chk("lat_count_n2", fifo_count, 1);
          chk("lat_data_n2", out_data, bits[8:1]);
        end
        repeat (6) @(posedge clk);
      end else begin
        repeat (10) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    send(mk(b, 1'b0, 1'b1), 11, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (fifo_count != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    chk("drain_empty", fifo_count, 0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_err"}, frame_err, 0);
  endtask

  initial begin
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single frame with latency checks
    exp_q.push_back(8'h1C);
    send(mk(8'h1C, 1'b0, 1'b1), 11, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("single_data", out_data, 8'h1C);
    chk("single_no_err", err_cycles, exp_err_cycles);
    drain();

    // Break sequence with consumer always ready
    out_ready = 1'b1;
    send_byte(8'hF0, 1);
    send_byte(8'h1C, 1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("break_count", fifo_count, 0);
    chk("break_sb", exp_q.size(), 0);

    // Parity error
`ifdef PS2_PARITY_CHECK_EN
    exp_err_cycles++;
    send(mk(8'h1C, 1'b1, 1'b1), 11, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("parity_err", err_cycles, exp_err_cycles);
    chk("parity_count", fifo_count, 0);
`else
    exp_q.push_back(8'h1C);
    send(mk(8'h1C, 1'b1, 1'b1), 11, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("parity_ignored_err", err_cycles, exp_err_cycles);
    chk("parity_ignored_count", fifo_count, 1);
    drain();
`endif

    // Stop-bit error
    exp_err_cycles++;
    send(mk(8'h33, 1'b0, 1'b0), 11, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stop_err", err_cycles, exp_err_cycles);
    chk("stop_count", fifo_count, 0);

    // Full FIFO with pop in the CHECK cycle
    for (int i = 0; i < DEPTH; i++) send_byte(8'h30 + 8'(i), 1);
    chk("full_count", fifo_count, DEPTH);
    exp_q.push_back(8'h40);
    send(mk(8'h40, 1'b0, 1'b1), 11, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("full_pop_count", fifo_count, DEPTH);
    chk("full_pop_ovf", overflow, 0);
    drain();

    // Overflow
    for (int i = 1; i <= 9; i++) send_byte(8'(i), i <= DEPTH);
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_flag", overflow, 1);
    drain();
    for (int i = 0; i < 3; i++) send_byte(8'h21 + 8'(i), 1);
    chk("refill_count", fifo_count, 3);
    drain();
    chk("ovf_sticky", overflow, 1);

    // Timeout on a partial frame
    send(mk(8'h77, 1'b0, 1'b1), 5, 0);
    repeat (TMO + 10) @(posedge clk);
    #1;
    send_byte(8'h5A, 1);
    chk("tmo_count", fifo_count, 1);
    chk("tmo_no_err", err_cycles, exp_err_cycles);
    drain();

    // Reset mid-frame with data buffered
    send_byte(8'h11, 1);
    send(mk(8'h22, 1'b0, 1'b1), 4, 0);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'h66, 1);
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_data", out_data, 8'h66);
    drain();

    chk("total_err_cycles", err_cycles, exp_err_cycles);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
